// File: rtl/mand_pixel_scheduler_pkg.sv
// Shared fixed-point constants and FSM encoding for the Mandelbrot pixel scheduler.
// c values are signed 4.23; solver result -1 marks a converged pixel.
package mand_defs;
  localparam int FRAC_BITS = 23;
  localparam int INT_BITS  = 4;
  localparam int C_W       = INT_BITS + FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SOLVE = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam logic signed [31:0] ITER_CONVERGED = -32'sd1;
endpackage

// File: rtl/mand_pixel_scheduler_if.sv
// Pixel result port towards the frame-buffer writer; valid/ready handshake.
// The scheduler drives the master side, the writer the slave side.
interface mand_pixel_scheduler_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic                pix_valid;
  logic                pix_ready;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic signed [31:0]  pix_iter;

  modport master (output pix_valid, output pix_x, output pix_y, output pix_iter, input pix_ready);
  modport slave  (input pix_valid, input pix_x, input pix_y, input pix_iter, output pix_ready);
endinterface

// File: rtl/mand_pixel_scheduler_coord_stepper.sv
// Raster walker: holds pixel x/y and the matching complex coordinate c.
// Real axis grows to the right, imaginary axis shrinks downward; sums wrap.
module coord_stepper
  import mand_defs::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  next_pixel,
  input  logic signed [C_W-1:0] i_re_start,
  input  logic signed [C_W-1:0] i_im_start,
  input  logic signed [C_W-1:0] i_step,
  output logic signed [C_W-1:0] o_c_re,
  output logic signed [C_W-1:0] o_c_im,
  output logic [X_W-1:0]        o_x,
  output logic [Y_W-1:0]        o_y,
  output logic                  last_col,
  output logic                  last_row
);
  logic signed [C_W-1:0] r_re_start;
  logic signed [C_W-1:0] r_step;
  logic signed [C_W-1:0] r_c_re;
  logic signed [C_W-1:0] r_c_im;
  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_re_start <= '0;
      r_step     <= '0;
      r_c_re     <= '0;
      r_c_im     <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (init) begin
      r_re_start <= i_re_start;
      r_step     <= i_step;
      r_c_re     <= i_re_start;
      r_c_im     <= i_im_start;
      r_x        <= '0;
      r_y        <= '0;
    end else if (next_pixel) begin
      if (!last_col) begin
        r_x    <= r_x + 1'b1;
        r_c_re <= r_c_re + r_step;
      end else begin
        r_x    <= '0;
        r_y    <= r_y + 1'b1;
        r_c_re <= r_re_start;
        r_c_im <= r_c_im - r_step;
      end
    end
  end

  assign last_col = (r_x == X_W'(H_PIXELS - 1));
  assign last_row = (r_y == Y_W'(V_PIXELS - 1));
  assign o_c_re   = r_c_re;
  assign o_c_im   = r_c_im;
  assign o_x      = r_x;
  assign o_y      = r_y;
endmodule

// File: rtl/mand_pixel_scheduler.sv
// Walks a frame in raster order, restarts the solver per pixel and emits (x, y, iterations).
// One pixel in flight; the result is held on the valid/ready port until accepted.
module mand_pixel_scheduler
  import mand_defs::*;
#(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int X_W      = 10,
  parameter int Y_W      = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [C_W-1:0] re_start,
  input  logic signed [C_W-1:0] im_start,
  input  logic signed [C_W-1:0] step,
  input  logic [9:0]            iter_limit,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  solver_reset,
  output logic signed [C_W-1:0] solver_c_re,
  output logic signed [C_W-1:0] solver_c_im,
  output logic [9:0]            solver_iter_limit,
  input  logic                  solver_ready,
  input  logic signed [31:0]    solver_out,
  mand_pixel_scheduler_if.master pix
);
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_capture;
  logic               w_hs;
  logic               w_last_pix;
  logic               w_last_col;
  logic               w_last_row;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic               r_busy;
  logic               r_frame_done;
  logic               r_pix_valid;
  logic [X_W-1:0]     r_pix_x;
  logic [Y_W-1:0]     r_pix_y;
  logic signed [31:0] r_pix_iter;
  logic [9:0]         r_iter_limit;

  coord_stepper #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_stepper (
    .clock      (clock),
    .reset      (reset),
    .init       (w_accept),
    .next_pixel (w_hs && !w_last_pix),
    .i_re_start (re_start),
    .i_im_start (im_start),
    .i_step     (step),
    .o_c_re     (solver_c_re),
    .o_c_im     (solver_c_im),
    .o_x        (w_x),
    .o_y        (w_y),
    .last_col   (w_last_col),
    .last_row   (w_last_row)
  );

  assign w_last_pix = w_last_col && w_last_row;

  // A start coinciding with frame_done is dropped so back-to-back frames need a fresh request.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !r_frame_done) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: w_state_nxt = ST_SOLVE;
      ST_SOLVE: begin
        if (solver_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (r_pix_valid && pix.pix_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = w_last_pix ? ST_IDLE : ST_LOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_x      <= '0;
      r_pix_y      <= '0;
      r_pix_iter   <= '0;
      r_iter_limit <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_hs && w_last_pix;
      if (w_accept) begin
        r_busy       <= 1'b1;
        r_iter_limit <= iter_limit;
      end else if (w_hs && w_last_pix) begin
        r_busy <= 1'b0;
      end
      if (w_capture) begin
        r_pix_valid <= 1'b1;
        r_pix_x     <= w_x;
        r_pix_y     <= w_y;
        r_pix_iter  <= solver_out;
      end else if (w_hs) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  // The solver runs only in SOLVE; everywhere else it is held in restart.
  assign solver_reset      = (r_state != ST_SOLVE);
  assign solver_iter_limit = r_iter_limit;
  assign busy              = r_busy;
  assign frame_done        = r_frame_done;
  assign pix.pix_valid     = r_pix_valid;
  assign pix.pix_x         = r_pix_x;
  assign pix.pix_y         = r_pix_y;
  assign pix.pix_iter      = r_pix_iter;
endmodule

// File: tb/tb_mand_pixel_scheduler.sv
// Directed bench for mand_pixel_scheduler on a 4x3 frame with a behavioural solver stub.
module tb_mand_pixel_scheduler;
  import mand_defs::*;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int XW  = 2;
  localparam int YW  = 2;
  localparam int RE0 = -16777216;
  localparam int IM0 = 8388608;
  localparam int STP = 4194304;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic signed [C_W-1:0] re_start = '0;
  logic signed [C_W-1:0] im_start = '0;
  logic signed [C_W-1:0] step = '0;
  logic [9:0]            iter_limit = '0;
  logic                  busy;
  logic                  frame_done;
  logic                  solver_reset;
  logic signed [C_W-1:0] solver_c_re;
  logic signed [C_W-1:0] solver_c_im;
  logic [9:0]            solver_iter_limit;
  logic                  s_ready = 1'b0;
  logic signed [31:0]    s_out = '0;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int hs_cnt = 0;
  int cnt = 0;
  logic prev_rst = 1'b1;
  logic stale_mode = 1'b0;
  int conv_idx = -1;

  mand_pixel_scheduler_if #(.X_W(XW), .Y_W(YW)) pix ();

  mand_pixel_scheduler #(
    .H_PIXELS (H),
    .V_PIXELS (V),
    .X_W      (XW),
    .Y_W      (YW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .re_start          (re_start),
    .im_start          (im_start),
    .step              (step),
    .iter_limit        (iter_limit),
    .busy              (busy),
    .frame_done        (frame_done),
    .solver_reset      (solver_reset),
    .solver_c_re       (solver_c_re),
    .solver_c_im       (solver_c_im),
    .solver_iter_limit (solver_iter_limit),
    .solver_ready      (s_ready),
    .solver_out        (s_out),
    .pix               (pix.master)
  );

  always #5 clock = ~clock;

  // Solver stub: result = x + 4*y recovered from c, ready three cycles after restart releases.
  // In stale mode ready lingers through EMIT and LOAD, as a real solver's might.
  always @(posedge clock) begin
    int px, py, pidx;
    px = (int'(solver_c_re) - RE0) / STP;
    py = (IM0 - int'(solver_c_im)) / STP;
    pidx = px + H * py;
    prev_rst <= solver_reset;
    if (solver_reset) begin
      cnt <= 0;
      if (!stale_mode || prev_rst) s_ready <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      s_ready <= (cnt == 2) || (stale_mode && s_ready);
      if (cnt == 2) s_out <= (pidx == conv_idx) ? ITER_CONVERGED : 32'(pidx);
    end
  end

  always @(posedge clock) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (pix.pix_valid && pix.pix_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_pixel(input int idx, input logic signed [31:0] exp_iter, input int bp);
    int n;
    n = 0;
    while (solver_reset !== 1'b0 && n < 40) begin @(negedge clock); n++; end
    chk($sformatf("p%0d_solve_entered", idx), solver_reset, 0);
    chk($sformatf("p%0d_c_re", idx), solver_c_re, RE0 + (idx % H) * STP);
    chk($sformatf("p%0d_c_im", idx), solver_c_im, IM0 - (idx / H) * STP);
    n = 0;
    while (pix.pix_valid !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    chk($sformatf("p%0d_valid", idx), pix.pix_valid, 1);
    chk($sformatf("p%0d_x", idx), pix.pix_x, idx % H);
    chk($sformatf("p%0d_y", idx), pix.pix_y, idx / H);
    chk($sformatf("p%0d_iter", idx), pix.pix_iter, exp_iter);
    for (int k = 0; k < bp; k++) begin
      @(negedge clock);
      chk($sformatf("p%0d_hold_valid", idx), pix.pix_valid, 1);
      chk($sformatf("p%0d_hold_x", idx), pix.pix_x, idx % H);
      chk($sformatf("p%0d_hold_iter", idx), pix.pix_iter, exp_iter);
      chk($sformatf("p%0d_hold_sreset", idx), solver_reset, 1);
    end
    if (bp > 0) pix.pix_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int fd0, hs0;
    pix.pix_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_pix_valid", pix.pix_valid, 0);
    chk("rst_solver_reset", solver_reset, 1);
    chk("rst_pix_iter", pix.pix_iter, 0);
    chk("rst_c_re", solver_c_re, 0);
    reset = 1'b1;
    @(negedge clock);

    // Frame 1: plain run with backpressure on pixel 2 and a start while busy
    re_start = RE0; im_start = IM0; step = STP; iter_limit = 10'd300;
    fd0 = fd_cnt; hs0 = hs_cnt;
    pulse_start();
    chk("f1_busy", busy, 1);
    chk("f1_iter_limit", solver_iter_limit, 300);
    re_start = 27'sd12345; iter_limit = 10'd9;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) pix.pix_ready = 1'b0;
      if (i == 6) pulse_start();
      run_pixel(i, 32'(i), (i == 2) ? 5 : 0);
    end
    chk("f1_frame_done", frame_done, 1);
    chk("f1_busy_fall", busy, 0);
    chk("f1_iter_limit_held", solver_iter_limit, 300);
    pulse_start();
    chk("f1_start_on_done_ignored", busy, 0);
    chk("f1_done_one_cycle", frame_done, 0);
    chk("f1_done_count", fd_cnt - fd0, 1);
    chk("f1_hs_count", hs_cnt - hs0, 12);

    // Frame 2: stale solver_ready, converged pixel 3, aborted by reset at pixel 5
    stale_mode = 1'b1; conv_idx = 3;
    re_start = RE0; iter_limit = 10'd500;
    pulse_start();
    chk("f2_accepted", busy, 1);
    chk("f2_iter_limit", solver_iter_limit, 500);
    for (int i = 0; i < 5; i++) run_pixel(i, (i == 3) ? ITER_CONVERGED : 32'(i), 0);
    fd0 = fd_cnt;
    pix.pix_ready = 1'b0;
    run_pixel(5, 32'sd5, 1);
    pix.pix_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    pix.pix_ready = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_pix_valid", pix.pix_valid, 0);
    chk("abort_solver_reset", solver_reset, 1);
    chk("abort_pix_x", pix.pix_x, 0);
    chk("abort_pix_y", pix.pix_y, 0);
    chk("abort_pix_iter", pix.pix_iter, 0);
    chk("abort_c_re", solver_c_re, 0);
    chk("abort_c_im", solver_c_im, 0);
    chk("abort_iter_limit", solver_iter_limit, 0);
    repeat (3) @(negedge clock);
    chk("abort_idle_sreset", solver_reset, 1);
    chk("abort_no_done", fd_cnt - fd0, 0);

    // Frame 3: fresh frame restarts at (0,0)
    stale_mode = 1'b0; conv_idx = -1;
    iter_limit = 10'd77;
    fd0 = fd_cnt; hs0 = hs_cnt;
    pulse_start();
    chk("f3_accepted", busy, 1);
    chk("f3_iter_limit", solver_iter_limit, 77);
    for (int i = 0; i < 12; i++) run_pixel(i, 32'(i), 0);
    chk("f3_frame_done", frame_done, 1);
    chk("f3_busy_fall", busy, 0);
    repeat (3) @(negedge clock);
    chk("f3_done_count", fd_cnt - fd0, 1);
    chk("f3_hs_count", hs_cnt - hs0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
